ball_engine: RTL and testbench
==============================

// Module: ball_engine
// PURPOSE
//   Pong ball physics for the 16x16 dot matrix. Moves the ball one dot per step, bounces it off
//   the top and bottom walls and the two paddles, and detects goals. Drives the x/y dot position
//   consumed by the matrix scan driver (x = column 0..15, y = row 0..15).
//   Sits between paddle/game control (upstream) and the screen scanner (downstream).
// PARAMETERS
//   STEP_CYCLES  600000  clk cycles per ball step (12MHz -> 20 steps/s); must be >= 2
//   PADDLE_LEN   4       paddle height in dots; 1..8
//   SERVE_STEPS  16      steps the ball is held at centre before launch
//   GOAL_STEPS   24      steps the ball is held in the goal column after a goal
// PORTS
//   clk      in   1  12MHz system clock
//   reset    in   1  synchronous, active-high
//   lpaddle  in   4  top row of left paddle (column 0); values > 16-PADDLE_LEN clamp to 16-PADDLE_LEN
//   rpaddle  in   4  top row of right paddle (column 15); same clamp
//   x        out  4  ball column
//   y        out  4  ball row
//   hit      out  1  1-cycle pulse on paddle bounce
//   goal_l   out  1  1-cycle pulse: left player scored (ball entered column 15)
//   goal_r   out  1  1-cycle pulse: right player scored (ball entered column 0)
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high. All regs update on posedge clk only.
//   - Reset values: x=7, y=7, dx=+1 (right), dy=+1 (down), state=SERVE, step counter=0, step
//     count=0, hit=goal_l=goal_r=0. Reset mid-step or mid-state aborts it; no pulse is emitted.
//   - Step strobe: counter 0..STEP_CYCLES-1. The strobe is high in the cycle the counter equals
//     STEP_CYCLES-1, and the counter wraps to 0 in that cycle. All motion happens on strobe cycles.
//   - Each strobe takes effect in one cycle: x/y/pulses are registered and visible on the next clock.
//   - States:
//     SERVE  ball held at (7,7). After SERVE_STEPS strobes -> PLAY. dx keeps its value;
//            dy = +1 at reset, else the inverse of dy at the moment of the goal.
//     PLAY   per strobe:
//            1. Wall: ny = y+dy. If y==0 and dy=-1, or y==15 and dy=+1, dy flips and ny = y-dy_old.
//            2. Paddle: if dx=-1 and x==1, the move enters column 0. If ny lies in
//               [lpaddle_c, lpaddle_c+PADDLE_LEN-1], dx flips to +1, x stays 1, y=ny, and hit pulses.
//               Otherwise x=0, y=ny, goal_r pulses, -> GOAL. Mirror rules apply for dx=+1,
//               x==14, rpaddle_c, column 15, and goal_l.
//            3. Otherwise x=x+dx, y=ny.
//            Paddle checks use the post-wall-bounce ny, so corner hits work.
//     GOAL   ball frozen in the goal column for GOAL_STEPS strobes. Then x=7, y=7, and
//            dx = direction toward the side that conceded -> SERVE.
//   - Paddle inputs are sampled only on strobe cycles; changes between strobes have no effect.
//   - Arithmetic is 4-bit unsigned with dx/dy as 1-bit sign flags. The bounds checks guarantee
//     x and y never wrap; x stays in 1..14 during PLAY.
//   - hit, goal_l, and goal_r are mutually exclusive and never high for more than 1 cycle.
// STRUCTURE
//   - Shared package pong_pkg: COLS=16, ROWS=16, CENTRE=7, state encoding
//     (SERVE=2'd0, PLAY=2'd1, GOAL=2'd2), direction encoding (0=+1, 1=-1).
//   - Sub-module step_timer #(STEP_CYCLES): prescaler that outputs the 1-cycle strobe.
//     It is reused for paddle motion timing.
//   - The remainder is a single FSM plus a position datapath in this file.
// TESTING  (bench uses STEP_CYCLES=4, SERVE_STEPS=2, GOAL_STEPS=2, PADDLE_LEN=4)
//   1. Reset held 3 cycles, then released -> x=7, y=7, no pulses. The first move comes after
//      2 serve strobes plus 1 play strobe: (8,8) at cycle 12.
//   2. Ball at y=15 with dy=+1 in PLAY, x=5, dx=+1 -> next strobe gives (6,14) with dy=-1.
//   3. Ball at (1,6), dx=-1, dy=+1, lpaddle=4 (ny=7 is within 4..7) -> x stays 1, y=7,
//      dx=+1, hit=1 for exactly 1 cycle.
//   4. Same as 3 but lpaddle=8 -> (0,7), goal_r=1 for 1 cycle. After 2 strobes: (7,7), dx=-1,
//      state SERVE, dy=-1.
//   5. Corner: ball at (14,15), dx=+1, dy=+1, rpaddle=14 (clamps to 12) -> ny=14 is within
//      12..15 -> hit, dx=-1, dy=-1, (14,14).
//   6. Assert reset in the strobe cycle of a goal -> no goal pulse; outputs return to reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: matrix geometry, ball FSM states, direction
// encoding and the paddle helpers used by the ball engine.
//   COLS/ROWS : dot-matrix size (16x16)
//   CENTRE    : serve position on both axes
//   state_t   : SERVE / PLAY / GOAL
//   dir_t     : 1-bit sign flag, 0 = +1, 1 = -1
package pong_pkg;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam logic [3:0] CENTRE = 4'd7;
    localparam logic [3:0] XMAX   = 4'(COLS - 1);
    localparam logic [3:0] YMAX   = 4'(ROWS - 1);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        GOAL  = 2'd2
    } state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    // Keep the whole paddle on screen: top row is limited to COLS-len.
    function automatic logic [3:0] clamp_paddle(input logic [3:0] top,
                                                input int unsigned len);
        logic [4:0] lim;
        lim = 5'(COLS - int'(len));
        if ({1'b0, top} > lim) return lim[3:0];
        return top;
    endfunction

    // True when row lies in [top, top+len-1]; top is already clamped.
    function automatic logic in_paddle(input logic [3:0] row,
                                       input logic [3:0] top,
                                       input int unsigned len);
        logic [4:0] bot;
        bot = {1'b0, top} + 5'(len - 1);
        return (row >= top) && ({1'b0, row} <= bot);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Prescaler producing a 1-cycle strobe every STEP_CYCLES clocks.
//   i_clk    : system clock
//   i_reset  : synchronous, active-high; counter restarts at 0
//   o_strobe : high in the cycle the counter equals STEP_CYCLES-1
module step_timer #(
    parameter int unsigned STEP_CYCLES = 600000
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_strobe
);

    localparam int unsigned CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign o_strobe = (r_count == LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (o_strobe) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Pong ball physics for the 16x16 dot matrix: serve hold, diagonal motion,
// wall and paddle bounces, goal detection and goal hold.
//   clk, reset      : 12MHz clock, synchronous active-high reset
//   lpaddle/rpaddle : top row of left (col 0) / right (col 15) paddle
//   x, y            : ball column / row
//   hit             : 1-cycle pulse on a paddle bounce
//   goal_l / goal_r : 1-cycle pulse when the ball enters column 15 / 0
module ball_engine
    import pong_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 600000,
    parameter int unsigned PADDLE_LEN  = 4,
    parameter int unsigned SERVE_STEPS = 16,
    parameter int unsigned GOAL_STEPS  = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lpaddle,
    input  logic [3:0] rpaddle,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       hit,
    output logic       goal_l,
    output logic       goal_r
);

    localparam int unsigned HOLD_MAX = (SERVE_STEPS > GOAL_STEPS) ? SERVE_STEPS : GOAL_STEPS;
    localparam int unsigned HW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] SERVE_LAST = HW'(SERVE_STEPS - 1);
    localparam logic [HW-1:0] GOAL_LAST  = HW'(GOAL_STEPS - 1);

    logic w_strobe;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_x, w_x_nx;
    logic [3:0]  r_y, w_y_nx;
    dir_t        r_dx, w_dx_nx;
    dir_t        r_dy, w_dy_nx;
    logic [HW-1:0] r_hold, w_hold_nx;
    logic        r_hit, w_hit_nx;
    logic        r_goal_l, w_goal_l_nx;
    logic        r_goal_r, w_goal_r_nx;

    // Post-wall-bounce row and direction, shared by the paddle checks.
    logic [3:0]  w_ny;
    dir_t        w_dy_b;
    logic [3:0]  w_lp, w_rp;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SERVE;
            r_x      <= CENTRE;
            r_y      <= CENTRE;
            r_dx     <= DIR_POS;
            r_dy     <= DIR_POS;
            r_hold   <= '0;
            r_hit    <= 1'b0;
            r_goal_l <= 1'b0;
            r_goal_r <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_dx     <= w_dx_nx;
            r_dy     <= w_dy_nx;
            r_hold   <= w_hold_nx;
            r_hit    <= w_hit_nx;
            r_goal_l <= w_goal_l_nx;
            r_goal_r <= w_goal_r_nx;
        end
    end

    always_comb begin
        w_lp = clamp_paddle(lpaddle, PADDLE_LEN);
        w_rp = clamp_paddle(rpaddle, PADDLE_LEN);

        w_dy_b = r_dy;
        if (r_dy == DIR_POS) begin
            if (r_y == YMAX) begin
                w_dy_b = DIR_NEG;
                w_ny   = r_y - 4'd1;
            end else begin
                w_ny   = r_y + 4'd1;
            end
        end else begin
            if (r_y == 4'd0) begin
                w_dy_b = DIR_POS;
                w_ny   = 4'd1;
            end else begin
                w_ny   = r_y - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_dx_nx     = r_dx;
        w_dy_nx     = r_dy;
        w_hold_nx   = r_hold;
        w_hit_nx    = 1'b0;
        w_goal_l_nx = 1'b0;
        w_goal_r_nx = 1'b0;

        if (w_strobe) begin
            case (r_state)
                SERVE: begin
                    if (r_hold == SERVE_LAST) begin
                        w_state_nx = PLAY;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx  = r_hold + 1'b1;
                    end
                end
                PLAY: begin
                    w_y_nx  = w_ny;
                    w_dy_nx = w_dy_b;
                    if (r_dx == DIR_NEG && r_x == 4'd1) begin
                        if (in_paddle(w_ny, w_lp, PADDLE_LEN)) begin
                            w_dx_nx  = DIR_POS;
                            w_hit_nx = 1'b1;
                        end else begin
                            w_x_nx      = 4'd0;
                            w_goal_r_nx = 1'b1;
                            w_state_nx  = GOAL;
                            w_hold_nx   = '0;
                        end
                    end else if (r_dx == DIR_POS && r_x == XMAX - 4'd1) begin
                        if (in_paddle(w_ny, w_rp, PADDLE_LEN)) begin
                            w_dx_nx  = DIR_NEG;
                            w_hit_nx = 1'b1;
                        end else begin
                            w_x_nx      = XMAX;
                            w_goal_l_nx = 1'b1;
                            w_state_nx  = GOAL;
                            w_hold_nx   = '0;
                        end
                    end else begin
                        w_x_nx = (r_dx == DIR_POS) ? r_x + 4'd1 : r_x - 4'd1;
                    end
                end
                GOAL: begin
                    if (r_hold == GOAL_LAST) begin
                        w_x_nx     = CENTRE;
                        w_y_nx     = CENTRE;
                        // Serve toward the side that conceded; ball sits in its column.
                        w_dx_nx    = (r_x == 4'd0) ? DIR_NEG : DIR_POS;
                        w_dy_nx    = (r_dy == DIR_POS) ? DIR_NEG : DIR_POS;
                        w_state_nx = SERVE;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx  = r_hold + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = SERVE;
                    w_hold_nx  = '0;
                end
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign hit    = r_hit;
    assign goal_l = r_goal_l;
    assign goal_r = r_goal_r;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with STEP_CYCLES=4, SERVE_STEPS=2,
// GOAL_STEPS=2, PADDLE_LEN=4. Strobes land on every 4th clock after reset
// release; outputs are sampled 1 time unit after a clock edge. Each check
// compares {x, y, hit, goal_l, goal_r} against a hand-traced trajectory.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] lpaddle, rpaddle;
    logic [3:0] x, y;
    logic       hit, goal_l, goal_r;

    int errors = 0;
    int checks = 0;
    logic [10:0] got, want;

    ball_engine #(
        .STEP_CYCLES (4),
        .PADDLE_LEN  (4),
        .SERVE_STEPS (2),
        .GOAL_STEPS  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .lpaddle (lpaddle),
        .rpaddle (rpaddle),
        .x       (x),
        .y       (y),
        .hit     (hit),
        .goal_l  (goal_l),
        .goal_r  (goal_r)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; lpaddle = 4'd0; rpaddle = 4'd12;
        tick(3);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL reset_state: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        reset = 1'b0;
        tick(11);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL serve_hold: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(1);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd8, 4'd8, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL first_move: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
    endtask

    task automatic test_diagonal;
        for (int i = 1; i <= 6; i++) begin
            tick(4);
            got = {x, y, hit, goal_l, goal_r}; want = {4'(8 + i), 4'(8 + i), 3'b000}; checks++;
            if (got !== want) begin errors++; $display("FAIL diagonal_%0d: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", i, got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        end
    endtask

    task automatic test_right_hit_and_wall;
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd15, 3'b100}; checks++;
        if (got !== want) begin errors++; $display("FAIL right_hit: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(1);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd15, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL hit_width: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(3);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd13, 4'd14, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL bottom_wall: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
    endtask

    task automatic test_left_hit_and_top_wall;
        repeat (12) tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd1, 4'd2, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL approach_left: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd1, 4'd1, 3'b100}; checks++;
        if (got !== want) begin errors++; $display("FAIL left_hit: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd2, 4'd0, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL row_zero: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd3, 4'd1, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL top_wall: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
    endtask

    task automatic test_paddle_clamp;
        rpaddle = 4'd15;    // clamps to 12 -> rows 12..15
        repeat (11) tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd12, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL approach_right: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd13, 3'b100}; checks++;
        if (got !== want) begin errors++; $display("FAIL clamp_hit: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
    endtask

    task automatic test_goal_r;
        lpaddle = 4'd4;     // rows 4..7; ball arrives at row 3
        repeat (13) tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd1, 4'd4, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL approach_goal_r: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd0, 4'd3, 3'b001}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_r: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(1);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd0, 4'd3, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_r_width: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(3);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd0, 4'd3, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_hold: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_recentre: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(8);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL reserve_hold: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);    // serve toward the left, dy inverted to +1
        got = {x, y, hit, goal_l, goal_r}; want = {4'd6, 4'd8, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL serve_left: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
    endtask

    task automatic test_goal_l;
        lpaddle = 4'd11;    // rows 11..14; ball arrives at row 14 (bottom edge of paddle)
        repeat (5) tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd1, 4'd13, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL approach_edge: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd1, 4'd14, 3'b100}; checks++;
        if (got !== want) begin errors++; $display("FAIL paddle_edge_hit: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(8);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd3, 4'd14, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL wall_after_hit: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        repeat (11) tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd3, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL approach_goal_l: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        rpaddle = 4'd3;     // rows 3..6; ball arrives at row 2
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd15, 4'd2, 3'b010}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_l: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(1);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd15, 4'd2, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_l_width: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(7);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL goal_l_recentre: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(12);   // serve right, dy inverted to +1
        got = {x, y, hit, goal_l, goal_r}; want = {4'd8, 4'd8, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL serve_right: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        repeat (6) tick(4);
    endtask

    task automatic test_reset_on_goal;
        rpaddle = 4'd0;     // the next strobe would score a goal at (15,15)
        tick(3);
        reset = 1'b1;
        tick(1);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL reset_on_goal: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(1);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd7, 4'd7, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL reset_no_pulse: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        reset = 1'b0;
        tick(12);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd8, 4'd8, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL relaunch: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        repeat (6) tick(4);
    endtask

    task automatic test_top_corner;
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd15, 4'd15, 3'b010}; checks++;
        if (got !== want) begin errors++; $display("FAIL corner_goal: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(20);   // two goal strobes, two serve strobes, first move up-right
        got = {x, y, hit, goal_l, goal_r}; want = {4'd8, 4'd6, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL serve_up: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        repeat (6) tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd0, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL approach_corner: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);    // wall flip to row 1, which the paddle at rows 0..3 covers
        got = {x, y, hit, goal_l, goal_r}; want = {4'd14, 4'd1, 3'b100}; checks++;
        if (got !== want) begin errors++; $display("FAIL corner_hit: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
        tick(4);
        got = {x, y, hit, goal_l, goal_r}; want = {4'd13, 4'd2, 3'b000}; checks++;
        if (got !== want) begin errors++; $display("FAIL after_corner: got x=%0d y=%0d p=%b want x=%0d y=%0d p=%b", got[10:7], got[6:3], got[2:0], want[10:7], want[6:3], want[2:0]); end
    endtask

    initial begin
        test_reset;
        test_diagonal;
        test_right_hit_and_wall;
        test_left_hit_and_top_wall;
        test_paddle_clamp;
        test_goal_r;
        test_goal_l;
        test_reset_on_goal;
        test_top_corner;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
